// File: rtl/sys_reset_seq.sv
// Reset/boot sequencer: synchronised (optionally debounced) reset sources drive a sequenced
// active-low SoC reset; boot/test mode latched at release. Debounce enabled by SYS_RESET_SEQ_DEBOUNCE_EN.
module sys_reset_seq #(
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned HoldCycles     = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       btn_reset_i,
    input  logic       vio_reset_i,
    input  logic [1:0] boot_mode_i,
    input  logic       test_mode_i,
    output logic       rst_no,
    output logic [1:0] boot_mode_o,
    output logic       test_mode_o,
    output logic       ready_o
);
    localparam int unsigned HoldW = $clog2(HoldCycles) + 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_e;

    // Synchroniser bit order: {test, boot[1], boot[0], btn, lock}
    logic [4:0] sync_q [SyncStages];
    logic [4:0] synced;
    logic [3:0] deb;  // {test, boot[1], boot[0], btn}
    logic       req;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {test_mode_i, boot_mode_i, btn_reset_i, locked_i};
            for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SyncStages-1];

`ifdef SYS_RESET_SEQ_DEBOUNCE_EN
    localparam int unsigned DebW = $clog2(DebounceCycles) + 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DebounceCycles - 1);

    logic [3:0]      stable_q, stable_d;
    logic [DebW-1:0] deb_cnt_q [4];
    logic [DebW-1:0] deb_cnt_d [4];

    always_comb begin
        stable_d = stable_q;
        for (int unsigned b = 0; b < 4; b++) begin
            deb_cnt_d[b] = '0;
            if (synced[b+1] != stable_q[b]) begin
                if (deb_cnt_q[b] == DebLast) stable_d[b] = synced[b+1];
                else                         deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= '0;
            for (int unsigned b = 0; b < 4; b++) deb_cnt_q[b] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int unsigned b = 0; b < 4; b++) deb_cnt_q[b] <= deb_cnt_d[b];
        end
    end

    assign deb = stable_q;
`else
    // DebounceCycles has no effect in this build
    logic unused_deb_cfg;
    assign unused_deb_cfg = (DebounceCycles != 0);
    assign deb = synced[4:1];
`endif

    assign req = deb[0] | vio_reset_i | ~synced[0];

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             rst_n_q;
    logic [1:0]       boot_q;
    logic             test_q;
    logic             release_edge;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!req) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                // A new request wins over hold completion in the same cycle
                if (req) begin
                    state_d = WAIT_LOCK;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (req) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign release_edge = (state_q == HOLD) && (state_d == RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            rst_n_q    <= 1'b0;
            boot_q     <= '0;
            test_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rst_n_q    <= (state_d == RUN);
            if (release_edge) begin
                boot_q <= deb[2:1];
                test_q <= deb[3];
            end
        end
    end

    assign rst_no      = rst_n_q;
    assign ready_o     = rst_n_q;
    assign boot_mode_o = boot_q;
    assign test_mode_o = test_q;
endmodule

// File: tb/tb_sys_reset_seq.sv
// Scoreboard bench for sys_reset_seq: driver pushes reference-model expectations per cycle,
// monitor pops and compares after each edge.
module tb_sys_reset_seq;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 16;

    logic       clk = 1'b1;
    logic       rst_i, locked_i, btn_reset_i, vio_reset_i, test_mode_i;
    logic [1:0] boot_mode_i;
    logic       rst_no, ready_o, test_mode_o;
    logic [1:0] boot_mode_o;

    always #5 clk = ~clk;

    sys_reset_seq #(.SyncStages(SYNC), .DebounceCycles(DEB), .HoldCycles(HOLD)) dut (
        .clk_i(clk), .rst_i(rst_i), .locked_i(locked_i), .btn_reset_i(btn_reset_i),
        .vio_reset_i(vio_reset_i), .boot_mode_i(boot_mode_i), .test_mode_i(test_mode_i),
        .rst_no(rst_no), .boot_mode_o(boot_mode_o), .test_mode_o(test_mode_o), .ready_o(ready_o)
    );

    typedef logic [4:0] exp_t;  // {rst_no, ready, boot[1:0], test}
    exp_t exp_q [$];
    int   checks = 0;
    int   passes = 0;
    int   pushes = 0;

    // Reference model: raw samples age through a SYNC-deep queue; the SoC is released once the
    // combined request has been low for HOLD+1 consecutive cycles.
    logic [4:0] line_q [$];
    logic [3:0] m_stable;
    int         m_run [4];
    int         m_clear;
    logic       m_rst_no;
    logic [1:0] m_boot;
    logic       m_test;

    task automatic model_reset();
        line_q.delete();
        for (int i = 0; i < SYNC; i++) line_q.push_back(5'b0);
        m_stable = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_clear  = 0;
        m_rst_no = 1'b0;
        m_boot   = '0;
        m_test   = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic [4:0] raw, input logic vi);
        logic [4:0] s;
        logic [3:0] d;
        logic       rq;
        logic       rel;
        if (r) begin
            model_reset();
        end else begin
            s = line_q[0];
`ifdef SYS_RESET_SEQ_DEBOUNCE_EN
            d = m_stable;
`else
            d = s[4:1];
`endif
            rq = d[0] | vi | ~s[0];
            m_clear = rq ? 0 : m_clear + 1;
            rel = (m_clear >= HOLD + 1);
            if (rel && !m_rst_no) begin
                m_boot = d[2:1];
                m_test = d[3];
            end
            m_rst_no = rel;
`ifdef SYS_RESET_SEQ_DEBOUNCE_EN
            // A bit flips once it has disagreed with the accepted value DEB cycles in a row
            for (int b = 0; b < 4; b++) begin
                if (s[b+1] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = s[b+1];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
`endif
            void'(line_q.pop_front());
            line_q.push_back(raw);
        end
    endtask

    logic       s_r, s_lk, s_bt, s_vi, s_tm;
    logic [1:0] s_bm;

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_i = s_r; locked_i = s_lk; btn_reset_i = s_bt; vio_reset_i = s_vi;
            boot_mode_i = s_bm; test_mode_i = s_tm;
            model_edge(s_r, {s_tm, s_bm, s_bt, s_lk}, s_vi);
            exp_q.push_back({m_rst_no, m_rst_no, m_boot, m_test});
            pushes++;
        end
    endtask

    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {rst_no, ready_o, boot_mode_o, test_mode_o};
                checks++;
                if (got === e) passes++;
                else $display("FAIL outputs check %0d t=%0t got %b want %b", checks, $time, got, e);
            end
        end
    end

    initial begin
        model_reset();
        s_r = 1'b1; s_lk = 1'b1; s_bt = 1'b0; s_vi = 1'b0; s_bm = 2'b10;
        s_tm = 1'($urandom_range(0, 1));
        run(3);
        s_r = 1'b0; run(30);
        s_lk = 1'b0; run(1); s_lk = 1'b1; run(30);
        s_bt = 1'b1; run(5); s_bt = 1'b0; run(30);
        s_bt = 1'b1; run(20); s_bt = 1'b0; run(40);
        s_bm = 2'b01; s_vi = 1'b1; run(1); s_vi = 1'b0; run(40);
        s_bm = 2'b11; run(20); s_vi = 1'b1; run(1); s_vi = 1'b0; run(40);
        for (int gap = 14; gap <= 18; gap++) begin
            s_vi = 1'b1; run(1); s_vi = 1'b0; run(gap);
        end
        run(30);
        s_vi = 1'b1; run(1); s_vi = 1'b0; run(8);
        s_r = 1'b1; run(1); s_r = 1'b0; run(40);
        for (int c = 0; c < 2000; c++) begin
            s_lk = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if (s_bt) begin
                if ($urandom_range(0, 5) == 0) s_bt = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                s_bt = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) s_bm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) s_tm = ~s_tm;
            s_vi = ($urandom_range(0, 149) == 0);
            s_r  = ($urandom_range(0, 499) == 0);
            run(1);
        end
        s_r = 1'b0; s_lk = 1'b1; s_bt = 1'b0; s_vi = 1'b0;
        run(40);
        @(posedge clk);
        #2;
        if (checks == pushes) passes++;
        else $display("FAIL drained got %0d compared want %0d", checks, pushes);
        checks++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
